// File: rtl/stone_ram_arbiter_pkg.sv
// rtl/stone_ram_arbiter_pkg.sv - shared FSM encodings, requester indices and default widths
package stone_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_t;

  localparam logic [1:0] REQ_DRAW  = 2'd0;
  localparam logic [1:0] REQ_ROPE1 = 2'd1;
  localparam logic [1:0] REQ_ROPE2 = 2'd2;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;

  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/stone_ram_arbiter_if.sv
// rtl/stone_ram_arbiter_if.sv - requester and stone RAM bus seen by the arbiter
interface stone_ram_arbiter_if
  import stone_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [2:0]        req;
  logic [2:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] wdata2;
  logic [2:0]        lock;
  logic [2:0]        ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport master (
    output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, lock, ram_q,
    input  ack, rdata, busy, ram_addr, ram_wdata, ram_wren
  );

  modport slave (
    input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, lock, ram_q,
    output ack, rdata, busy, ram_addr, ram_wdata, ram_wren
  );
endinterface

// File: rtl/stone_ram_arbiter_select.sv
// rtl/stone_ram_arbiter_select.sv - combinational grant pick: draw priority, rope starvation override, rope round-robin
module stone_arb_select
  import stone_ram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic [2:0] i_req,
  input  logic [3:0] i_cnt1,
  input  logic [3:0] i_cnt2,
  input  logic       i_rr_ptr,
  input  logic       i_lock_valid,
  input  logic [1:0] i_lock_owner,
  output logic       o_grant_valid,
  output logic [1:0] o_grant_idx
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       w_starve1;
  logic       w_starve2;
  logic [1:0] w_rope_pick;

  assign w_starve1 = i_req[1] && (i_cnt1 >= LIMIT);
  assign w_starve2 = i_req[2] && (i_cnt2 >= LIMIT);
  // Pointer only matters when both ropes compete; otherwise the lone requester is picked.
  assign w_rope_pick = (i_req[1] && i_req[2]) ? (i_rr_ptr ? REQ_ROPE2 : REQ_ROPE1)
                                              : (i_req[1] ? REQ_ROPE1 : REQ_ROPE2);

  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = REQ_DRAW;
    if (i_lock_valid) begin
      o_grant_valid = i_req[i_lock_owner];
      o_grant_idx   = i_lock_owner;
    end else if (w_starve1 || w_starve2) begin
      o_grant_valid = 1'b1;
      o_grant_idx   = (w_starve1 && w_starve2) ? w_rope_pick
                                               : (w_starve1 ? REQ_ROPE1 : REQ_ROPE2);
    end else if (i_req[0]) begin
      o_grant_valid = 1'b1;
      o_grant_idx   = REQ_DRAW;
    end else if (i_req[2:1] != 2'b00) begin
      o_grant_valid = 1'b1;
      o_grant_idx   = w_rope_pick;
    end
  end
endmodule

// File: rtl/stone_ram_arbiter.sv
// rtl/stone_ram_arbiter.sv - 3-requester stone RAM arbiter; STONE_ARB_LOCK_EN enables read-modify-write locking
module stone_ram_arbiter
  import stone_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input logic                clock,
  input logic                reset,
  stone_ram_arbiter_if.slave bus
);
  arb_state_t        r_state;
  logic [1:0]        r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_ram_wren;
  logic [2:0]        r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_busy;
  logic [3:0]        r_cnt1;
  logic [3:0]        r_cnt2;
  logic              r_rr_ptr;

  logic              w_lock_valid;
  logic [1:0]        w_lock_owner;
  logic              w_grant_valid;
  logic [1:0]        w_grant_idx;
  logic              w_grant;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_we;

`ifdef STONE_ARB_LOCK_EN
  logic       r_lock_valid;
  logic [1:0] r_lock_owner;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lock_valid <= 1'b0;
      r_lock_owner <= REQ_DRAW;
    end else if (r_state == ST_ACK) begin
      r_lock_valid <= bus.lock[r_owner];
      r_lock_owner <= r_owner;
    end
  end

  assign w_lock_valid = r_lock_valid;
  assign w_lock_owner = r_lock_owner;
`else
  logic w_unused_lock;
  assign w_unused_lock = ^bus.lock;
  assign w_lock_valid  = 1'b0;
  assign w_lock_owner  = REQ_DRAW;
`endif

  stone_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .i_req        (bus.req),
    .i_cnt1       (r_cnt1),
    .i_cnt2       (r_cnt2),
    .i_rr_ptr     (r_rr_ptr),
    .i_lock_valid (w_lock_valid),
    .i_lock_owner (w_lock_owner),
    .o_grant_valid(w_grant_valid),
    .o_grant_idx  (w_grant_idx)
  );

  assign w_grant = (r_state == ST_IDLE) && w_grant_valid;

  always_comb begin
    w_sel_addr  = bus.addr0;
    w_sel_wdata = bus.wdata0;
    w_sel_we    = bus.we[w_grant_idx];
    case (w_grant_idx)
      REQ_ROPE1: begin
        w_sel_addr  = bus.addr1;
        w_sel_wdata = bus.wdata1;
      end
      REQ_ROPE2: begin
        w_sel_addr  = bus.addr2;
        w_sel_wdata = bus.wdata2;
      end
      default: ;
    endcase
  end

  // Wait counters only age on draw grants, so rope-vs-rope service never trips the override.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt1 <= 4'd0;
      r_cnt2 <= 4'd0;
    end else begin
      if (!bus.req[1]) begin
        r_cnt1 <= 4'd0;
      end else if (w_grant) begin
        if (w_grant_idx == REQ_ROPE1)
          r_cnt1 <= 4'd0;
        else if (w_grant_idx == REQ_DRAW && r_cnt1 != 4'hF)
          r_cnt1 <= r_cnt1 + 4'd1;
      end
      if (!bus.req[2]) begin
        r_cnt2 <= 4'd0;
      end else if (w_grant) begin
        if (w_grant_idx == REQ_ROPE2)
          r_cnt2 <= 4'd0;
        else if (w_grant_idx == REQ_DRAW && r_cnt2 != 4'hF)
          r_cnt2 <= r_cnt2 + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= REQ_DRAW;
      r_we        <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_wren  <= 1'b0;
      r_ack       <= 3'b000;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_rr_ptr    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state     <= ST_ISSUE;
            r_busy      <= 1'b1;
            r_owner     <= w_grant_idx;
            r_we        <= w_sel_we;
            r_ram_addr  <= w_sel_addr;
            r_ram_wdata <= w_sel_wdata;
            r_ram_wren  <= w_sel_we;
            if (w_grant_idx == REQ_ROPE1) r_rr_ptr <= 1'b1;
            if (w_grant_idx == REQ_ROPE2) r_rr_ptr <= 1'b0;
          end
        end
        ST_ISSUE: begin
          r_state    <= ST_WAIT;
          r_ram_wren <= 1'b0;
        end
        ST_WAIT: begin
          r_state     <= ST_ACK;
          r_ack       <= idx_to_onehot(r_owner);
          r_ram_addr  <= '0;
          r_ram_wdata <= '0;
          if (!r_we) r_rdata <= bus.ram_q;
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_ack   <= 3'b000;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack       = r_ack;
  assign bus.rdata     = r_rdata;
  assign bus.busy      = r_busy;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ram_wren  = r_ram_wren;
endmodule

// File: tb/tb_stone_ram_arbiter.sv
// tb/tb_stone_ram_arbiter.sv - directed self-checking bench for stone_ram_arbiter
module tb_stone_ram_arbiter;
  import stone_ram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [31:0] mem [16];
  logic [2:0]  ack_seq [16];
  int          ack_cyc [16];
  int          ack_got;

  stone_ram_arbiter_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  stone_ram_arbiter #(.ADDR_W(4), .DATA_W(32), .STARVE_LIMIT(8)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Single-port RAM model with one-cycle registered read.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 + i;
      mem[5] <= 32'hA5A5_0003;
    end else if (bus.ram_wren) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_q <= mem[bus.ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req = 3'b000; bus.we = 3'b000; bus.lock = 3'b000;
    bus.addr0 = 4'd0; bus.addr1 = 4'd0; bus.addr2 = 4'd0;
    bus.wdata0 = 32'd0; bus.wdata1 = 32'd0; bus.wdata2 = 32'd0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic run_txn(input logic [2:0] r, input logic w, input logic [3:0] a,
                         input logic [31:0] d, output logic [2:0] ack_o,
                         output logic [31:0] rd_o, output int wren_n, output int lat);
    bus.addr0 = a; bus.addr1 = a; bus.addr2 = a;
    bus.wdata0 = d; bus.wdata1 = d; bus.wdata2 = d;
    bus.we = w ? r : 3'b000;
    bus.req = r;
    ack_o = 3'b000; rd_o = 32'd0; wren_n = 0; lat = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) bus.req = 3'b000;
      if (bus.ram_wren) wren_n++;
      if (bus.ack != 3'b000) begin
        ack_o = bus.ack; rd_o = bus.rdata; lat = i;
        break;
      end
    end
    tick();
  endtask

  task automatic collect_acks(input int n);
    ack_got = 0;
    for (int c = 1; c <= n * 4 + 8; c++) begin
      tick();
      if (bus.ack != 3'b000) begin
        ack_seq[ack_got] = bus.ack;
        ack_cyc[ack_got] = c;
        ack_got++;
        if (ack_got == n) break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    n_checks++; if (bus.ack !== 3'b000) begin n_fail++; $display("FAIL reset_ack: got %b expected 000", bus.ack); end
    n_checks++; if (bus.rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.ram_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b expected 0", bus.ram_wren); end
    n_checks++; if (bus.ram_addr !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.ram_addr); end
    n_checks++; if (bus.ram_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", bus.ram_wdata); end
    apply_reset();
  endtask

  task automatic test_single_read();
    apply_reset();
    bus.addr1 = 4'd5; bus.we = 3'b000; bus.req = 3'b010;
    tick();
    n_checks++; if (bus.ram_addr !== 4'd5) begin n_fail++; $display("FAIL read_issue_addr: got %h expected 5", bus.ram_addr); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL read_busy: got %b expected 1", bus.busy); end
    n_checks++; if (bus.ram_wren !== 1'b0) begin n_fail++; $display("FAIL read_wren: got %b expected 0", bus.ram_wren); end
    bus.req = 3'b000; bus.addr1 = 4'd7;
    tick();
    n_checks++; if (bus.ram_addr !== 4'd5) begin n_fail++; $display("FAIL read_latched_addr: got %h expected 5", bus.ram_addr); end
    n_checks++; if (bus.ack !== 3'b000) begin n_fail++; $display("FAIL read_early_ack: got %b expected 000", bus.ack); end
    tick();
    n_checks++; if (bus.ack !== 3'b010) begin n_fail++; $display("FAIL read_ack: got %b expected 010", bus.ack); end
    n_checks++; if (bus.rdata !== 32'hA5A5_0003) begin n_fail++; $display("FAIL read_rdata: got %h expected a5a50003", bus.rdata); end
    n_checks++; if (bus.ram_addr !== 4'd0) begin n_fail++; $display("FAIL read_ack_addr: got %h expected 0", bus.ram_addr); end
    tick();
    n_checks++; if (bus.ack !== 3'b000) begin n_fail++; $display("FAIL read_ack_pulse: got %b expected 000", bus.ack); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL read_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_write_read();
    logic [2:0]  a;
    logic [31:0] rd;
    int          wn, lat;
    run_txn(3'b100, 1'b1, 4'd3, 32'h1234_0002, a, rd, wn, lat);
    n_checks++; if (a !== 3'b100) begin n_fail++; $display("FAIL wr_ack: got %b expected 100", a); end
    n_checks++; if (wn !== 1) begin n_fail++; $display("FAIL wr_wren_cycles: got %0d expected 1", wn); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    n_checks++; if (rd !== 32'hA5A5_0003) begin n_fail++; $display("FAIL wr_rdata_hold: got %h expected a5a50003", rd); end
    run_txn(3'b100, 1'b0, 4'd3, 32'hFFFF_FFFF, a, rd, wn, lat);
    n_checks++; if (a !== 3'b100) begin n_fail++; $display("FAIL rd_back_ack: got %b expected 100", a); end
    n_checks++; if (rd !== 32'h1234_0002) begin n_fail++; $display("FAIL rd_back_data: got %h expected 12340002", rd); end
    n_checks++; if (wn !== 0) begin n_fail++; $display("FAIL rd_back_wren: got %0d expected 0", wn); end
  endtask

  task automatic test_contention();
    logic [2:0] exp_c [12];
    exp_c = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
              3'b010, 3'b100, 3'b001, 3'b001};
    apply_reset();
    bus.req = 3'b111;
    collect_acks(12);
    bus.req = 3'b000;
    n_checks++; if (ack_got !== 12) begin n_fail++; $display("FAIL cont_count: got %0d expected 12", ack_got); end
    for (int k = 0; k < 12; k++) begin
      if (k < ack_got) begin
        n_checks++;
        if (ack_seq[k] !== exp_c[k]) begin n_fail++; $display("FAIL cont_grant%0d: got %b expected %b", k, ack_seq[k], exp_c[k]); end
      end
    end
    n_checks++; if (ack_cyc[1] - ack_cyc[0] !== 4) begin n_fail++; $display("FAIL cont_spacing: got %0d expected 4", ack_cyc[1] - ack_cyc[0]); end
    repeat (4) tick();
  endtask

  task automatic test_round_robin();
    apply_reset();
    bus.req = 3'b110;
    collect_acks(3);
    bus.req = 3'b000;
    n_checks++; if (ack_seq[0] !== 3'b010) begin n_fail++; $display("FAIL rr_0: got %b expected 010", ack_seq[0]); end
    n_checks++; if (ack_seq[1] !== 3'b100) begin n_fail++; $display("FAIL rr_1: got %b expected 100", ack_seq[1]); end
    n_checks++; if (ack_seq[2] !== 3'b010) begin n_fail++; $display("FAIL rr_2: got %b expected 010", ack_seq[2]); end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    logic seen_ack;
    apply_reset();
    bus.addr1 = 4'd9; bus.wdata1 = 32'hDEAD_BEEF; bus.we = 3'b010; bus.req = 3'b010;
    tick();
    n_checks++; if (bus.ram_wren !== 1'b1) begin n_fail++; $display("FAIL mid_issue_wren: got %b expected 1", bus.ram_wren); end
    bus.req = 3'b000;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.ack !== 3'b000) begin n_fail++; $display("FAIL mid_ack: got %b expected 000", bus.ack); end
    n_checks++; if (bus.ram_wren !== 1'b0) begin n_fail++; $display("FAIL mid_wren: got %b expected 0", bus.ram_wren); end
    n_checks++; if (bus.ram_addr !== 4'd0) begin n_fail++; $display("FAIL mid_addr: got %h expected 0", bus.ram_addr); end
    n_checks++; if (bus.ram_wdata !== 32'd0) begin n_fail++; $display("FAIL mid_wdata: got %h expected 0", bus.ram_wdata); end
    n_checks++; if (bus.rdata !== 32'd0) begin n_fail++; $display("FAIL mid_rdata: got %h expected 0", bus.rdata); end
    clear_inputs();
    repeat (2) tick();
    rst = 1'b0;
    seen_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.ack != 3'b000 || bus.ram_wren) seen_ack = 1'b1;
    end
    n_checks++; if (seen_ack !== 1'b0) begin n_fail++; $display("FAIL mid_no_ack_after: got %b expected 0", seen_ack); end
  endtask

`ifdef STONE_ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    bus.addr1 = 4'd2; bus.we = 3'b000; bus.lock = 3'b010; bus.req = 3'b010;
    ack_got = 0;
    for (int c = 0; c < 40 && ack_got < 3; c++) begin
      tick();
      if (ack_got == 0 && bus.busy) begin bus.req = 3'b011; bus.we = 3'b010; end
      if (ack_got == 1 && bus.busy && bus.ack == 3'b000) bus.lock = 3'b000;
      if (bus.ack != 3'b000) begin
        ack_seq[ack_got] = bus.ack;
        ack_got++;
        if (ack_got == 2) begin bus.req = 3'b001; bus.we = 3'b000; end
      end
    end
    clear_inputs();
    n_checks++; if (ack_got !== 3) begin n_fail++; $display("FAIL lock_count: got %0d expected 3", ack_got); end
    n_checks++; if (ack_seq[0] !== 3'b010) begin n_fail++; $display("FAIL lock_0: got %b expected 010", ack_seq[0]); end
    n_checks++; if (ack_seq[1] !== 3'b010) begin n_fail++; $display("FAIL lock_1: got %b expected 010", ack_seq[1]); end
    n_checks++; if (ack_seq[2] !== 3'b001) begin n_fail++; $display("FAIL lock_2: got %b expected 001", ack_seq[2]); end
    repeat (4) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_round_robin();
    test_reset_mid();
`ifdef STONE_ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
